// File: rtl/awg_segment_sequencer.sv
// Segment scheduler for the waveform engine: plays a programmable table of pulse segments,
// repeating the table a programmed number of times. Optional LMFC alignment: AWG_SEQ_LMFC_ALIGN_EN.
module awg_segment_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          i_cfg_we,
    input  logic [AW-1:0] i_cfg_addr,
    input  logic [95:0]   i_cfg_data,
    input  logic [AW:0]   i_num_seg,
    input  logic [15:0]   i_loop_cnt,
    input  logic          i_start,
    input  logic          i_stop,
    input  logic          i_dac_ready,
    input  logic          i_dac_lmfc,
    output logic          o_trigger,
    output logic [15:0]   o_valid_amp,
    output logic [15:0]   o_zero_amp,
    output logic [31:0]   o_data_duration,
    output logic [31:0]   o_zero_duration,
    output logic          o_stop,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_TRIG,
        S_RUN,
        S_NEXT
    } state_e;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [95:0]   r_table [DEPTH];
    logic [95:0]   r_rd_data;
    logic [AW-1:0] r_idx;
    logic [AW:0]   r_num_seg;
    logic [15:0]   r_loop_cnt;
    logic [15:0]   r_loops_left;
    logic [32:0]   r_cnt;
    logic [15:0]   r_valid_amp;
    logic [15:0]   r_zero_amp;
    logic [31:0]   r_data_dur;
    logic [31:0]   r_zero_dur;
    logic          r_stop;
    logic          r_cfg_err;

    logic          w_start_ok;
    logic          w_arm_go;
    logic          w_last_seg;
    logic          w_last_pass;
    logic [32:0]   w_sum;
    logic [32:0]   w_seg_len;
    logic          w_trigger;
    logic          w_done;

`ifdef AWG_SEQ_LMFC_ALIGN_EN
    logic [1:0] r_lmfc_sync;
    logic       r_lmfc_prev;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_lmfc_sync <= 2'b00;
            r_lmfc_prev <= 1'b0;
        end else begin
            r_lmfc_sync <= {r_lmfc_sync[0], i_dac_lmfc};
            r_lmfc_prev <= r_lmfc_sync[1];
        end
    end

    assign w_arm_go = i_dac_ready && r_lmfc_sync[1] && !r_lmfc_prev;
`else
    logic w_lmfc_unused;
    assign w_lmfc_unused = i_dac_lmfc;
    assign w_arm_go      = i_dac_ready;
`endif

    assign w_start_ok  = i_start && (i_num_seg != '0) && (i_num_seg <= DEPTH_L);
    assign w_last_seg  = ({1'b0, r_idx} == (r_num_seg - 1'b1));
    assign w_last_pass = (r_loop_cnt != 16'd0) && (r_loops_left == 16'd1);
    assign w_sum       = {1'b0, r_data_dur} + {1'b0, r_zero_dur};
    assign w_seg_len   = (w_sum == 33'd0) ? 33'd1 : w_sum;

    // The trigger cycle counts as the first cycle of the segment, so RUN lasts len-1 cycles.
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_trigger   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: if (w_start_ok) w_state_nxt = S_LOAD;
            S_LOAD: w_state_nxt = S_ARM;
            S_ARM:  if (w_arm_go) w_state_nxt = S_TRIG;
            S_TRIG: begin
                w_trigger   = 1'b1;
                w_state_nxt = (w_seg_len == 33'd1) ? S_NEXT : S_RUN;
            end
            S_RUN:  if (r_cnt == 33'd2) w_state_nxt = S_NEXT;
            S_NEXT: begin
                if (w_last_seg && w_last_pass) begin
                    w_done      = !i_stop;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_stop) w_state_nxt = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_rd_data    <= '0;
            r_idx        <= '0;
            r_num_seg    <= '0;
            r_loop_cnt   <= '0;
            r_loops_left <= '0;
            r_cnt        <= '0;
            r_valid_amp  <= '0;
            r_zero_amp   <= '0;
            r_data_dur   <= '0;
            r_zero_dur   <= '0;
            r_stop       <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_stop    <= i_stop;
            r_cfg_err <= i_cfg_we && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok && !i_stop) begin
                        r_num_seg    <= i_num_seg;
                        r_loop_cnt   <= i_loop_cnt;
                        r_loops_left <= i_loop_cnt;
                        r_idx        <= '0;
                    end
                end
                S_LOAD: r_rd_data <= r_table[r_idx];
                S_ARM: begin
                    r_valid_amp <= r_rd_data[95:80];
                    r_zero_amp  <= r_rd_data[79:64];
                    r_data_dur  <= r_rd_data[63:32];
                    r_zero_dur  <= r_rd_data[31:0];
                end
                S_TRIG: r_cnt <= w_seg_len;
                S_RUN:  r_cnt <= r_cnt - 1'b1;
                S_NEXT: begin
                    if (w_last_seg) begin
                        r_idx <= '0;
                        if (r_loop_cnt != 16'd0) r_loops_left <= r_loops_left - 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the segment table is storage, not control state, so it is deliberately left unreset.
    always_ff @(posedge sys_clk) begin
        if (i_cfg_we && (r_state == S_IDLE)) r_table[i_cfg_addr] <= i_cfg_data;
    end

    assign o_trigger       = w_trigger;
    assign o_done          = w_done;
    assign o_busy          = (r_state != S_IDLE);
    assign o_stop          = r_stop;
    assign o_cfg_err       = r_cfg_err;
    assign o_valid_amp     = r_valid_amp;
    assign o_zero_amp      = r_zero_amp;
    assign o_data_duration = r_data_dur;
    assign o_zero_duration = r_zero_dur;

endmodule
